// File: rtl/kc_pkg.sv
// Shared definitions for the pushbutton conditioner.
// State encoding and default debounce timing.
package kc_pkg;

    typedef enum logic [1:0] {
        KC_IDLE  = 2'd0,
        KC_PWAIT = 2'd1,
        KC_DOWN  = 2'd2,
        KC_RWAIT = 2'd3
    } kc_state_t;

    localparam int KC_DEBOUNCE_DEFAULT = 500000;
    localparam int KC_CNT_W_DEFAULT    = 19;

endpackage

// File: rtl/key_debounce_cell.sv
// One pushbutton channel: 2-flop sync, debounce FSM, strobes, sticky event.
// Ports: clk, rst_n (async low), key_n (raw, 0=down), ack | level, press, drop, sticky.
module key_debounce_cell
    import kc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = KC_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic ack,
    output logic level,
    output logic press,
    output logic drop,
    output logic sticky
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s0;
    logic             s1;
    logic             p;
    kc_state_t        state;
    logic [CNT_W-1:0] cnt;

    assign p = ~s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0     <= 1'b1;
            s1     <= 1'b1;
            state  <= KC_IDLE;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            drop   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            s0    <= key_n;
            s1    <= s0;
            press <= 1'b0;
            drop  <= 1'b0;
            // An ack seen while press is showing loses to that press.
            sticky <= sticky & ~(ack & ~press);
            unique case (state)
                KC_IDLE: begin
                    if (p) begin
                        state <= KC_PWAIT;
                        cnt   <= ONE;
                    end
                end
                KC_PWAIT: begin
                    if (!p) begin
                        state <= KC_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state  <= KC_DOWN;
                        cnt    <= '0;
                        level  <= 1'b1;
                        press  <= 1'b1;
                        sticky <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                KC_DOWN: begin
                    if (!p) begin
                        state <= KC_RWAIT;
                        cnt   <= ONE;
                    end
                end
                KC_RWAIT: begin
                    if (p) begin
                        state <= KC_DOWN;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= KC_IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                        drop  <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions NKEYS raw active-low pushbuttons into clean levels and strobes.
// Ports: Clock, Reset (async low), KEY_n, Ack | Level, Press, Release, Event.
module key_conditioner
    import kc_pkg::*;
#(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = KC_CNT_W_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [NKEYS-1:0] KEY_n,
    input  logic [NKEYS-1:0] Ack,
    output logic [NKEYS-1:0] Level,
    output logic [NKEYS-1:0] Press,
    output logic [NKEYS-1:0] Release,
    output logic [NKEYS-1:0] Event
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk   (Clock),
            .rst_n (Reset),
            .key_n (KEY_n[i]),
            .ack   (Ack[i]),
            .level (Level[i]),
            .press (Press[i]),
            .drop  (Release[i]),
            .sticky(Event[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_key_conditioner;

    logic       Clock;
    logic       Reset;
    logic [3:0] KEY_n;
    logic [3:0] Ack;
    logic [3:0] Level;
    logic [3:0] Press;
    logic [3:0] Release;
    logic [3:0] Event;

    int checks;
    int errors;

    key_conditioner #(
        .NKEYS          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .KEY_n  (KEY_n),
        .Ack    (Ack),
        .Level  (Level),
        .Press  (Press),
        .Release(Release),
        .Event  (Event)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] e);
        chk({tag, "_level"}, Level, l);
        chk({tag, "_press"}, Press, p);
        chk({tag, "_release"}, Release, r);
        chk({tag, "_event"}, Event, e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        KEY_n  = 4'b0000;
        Ack    = 4'b0000;

        // 1) all keys held through reset, then released from reset
        repeat (3) tick();
        chk_all("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        Reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t1_wait_lvl", Level, 4'b0000);
            chk("t1_wait_prs", Press, 4'b0000);
        end
        tick();
        chk_all("t1_e6", 4'b1111, 4'b1111, 4'b0000, 4'b1111);
        tick();
        chk_all("t1_e7", 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        Ack = 4'b1111;
        tick();
        Ack = 4'b0000;
        chk("t1_ack", Event, 4'b0000);

        // release all
        KEY_n = 4'b1111;
        repeat (5) tick();
        chk("rel_e5_lvl", Level, 4'b1111);
        chk("rel_e5_rel", Release, 4'b0000);
        tick();
        chk_all("rel_e6", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        tick();
        chk("rel_e7_rel", Release, 4'b0000);

        // 2) 3-cycle glitch on key 2
        KEY_n = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) KEY_n = 4'b1111;
            tick();
            chk("t2_lvl", Level, 4'b0000);
            chk("t2_prs", Press, 4'b0000);
        end

        // 3) key 0 press, then ack at edge 10
        KEY_n = 4'b1110;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t3_wait_prs", Press, 4'b0000);
        end
        tick();
        chk_all("t3_e6", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        tick();
        chk_all("t3_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        repeat (3) tick();
        chk("t3_e10_evt", Event, 4'b0001);
        Ack = 4'b0001;
        tick();
        Ack = 4'b0000;
        chk("t3_e11_evt", Event, 4'b0000);

        // 4) key 1: press, ack, release, re-press with ack colliding
        KEY_n = 4'b1100;
        repeat (6) tick();
        chk("t4_p1_prs", Press, 4'b0010);
        tick();
        Ack = 4'b0010;
        tick();
        Ack = 4'b0000;
        chk("t4_p1_ack", Event, 4'b0000);
        KEY_n = 4'b1110;
        repeat (6) tick();
        chk("t4_rel", Release, 4'b0010);
        tick();
        KEY_n = 4'b1100;
        repeat (5) tick();
        chk("t4_e5_evt", Event, 4'b0000);
        Ack = 4'b0010;
        tick();
        chk("t4_e6_prs", Press, 4'b0010);
        chk("t4_e6_evt", Event, 4'b0010);
        tick();
        Ack = 4'b0000;
        chk("t4_e7_evt", Event, 4'b0010);
        tick();
        chk("t4_hold_evt", Event, 4'b0010);
        Ack = 4'b0010;
        tick();
        Ack = 4'b0000;
        chk("t4_clr_evt", Event, 4'b0000);

        // 5) key 3: press, short bounce, then real release
        KEY_n = 4'b0100;
        repeat (7) tick();
        chk("t5_down_lvl", Level, 4'b1011);
        Ack = 4'b1000;
        tick();
        Ack = 4'b0000;
        KEY_n = 4'b1100;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) KEY_n = 4'b0100;
            tick();
            chk("t5_bnc_lvl", Level, 4'b1011);
            chk("t5_bnc_rel", Release, 4'b0000);
        end
        KEY_n = 4'b1100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t5_wait_rel", Release, 4'b0000);
        end
        tick();
        chk_all("t5_e6", 4'b0011, 4'b0000, 4'b1000, 4'b0000);
        tick();
        chk("t5_e7_rel", Release, 4'b0000);

        // 6) reset during PWAIT on key 0
        KEY_n = 4'b1101;
        repeat (7) tick();
        chk("t6_pre_lvl", Level, 4'b0010);
        KEY_n = 4'b1100;
        repeat (3) tick();
        #2;
        Reset = 1'b0;
        #1;
        chk_all("t6_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) tick();
        chk_all("t6_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        Reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t6_wait_lvl", Level, 4'b0000);
            chk("t6_wait_prs", Press, 4'b0000);
        end
        tick();
        chk_all("t6_e6", 4'b0011, 4'b0011, 4'b0000, 4'b0011);
        tick();
        chk("t6_e7_prs", Press, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
